cache_ctrl: RTL and testbench

- Miss-handling controller that sits directly upstream of one direct-mapped, one-word-per-line cache `group`.
- Takes CPU load/store requests, probes the group, and on a miss writes back a dirty victim over the memory bus, then refills the line.
- Replays the access after refill, so every completed access is a group hit.
- Stalls the CPU for the duration of miss handling.

---
 rtl/cache_ctrl_pkg.sv | 20 ++
 rtl/cache_stat.sv | 32 +++
 rtl/cache_ctrl.sv | 150 +++++++++++++++
 tb/tb_cache_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared geometry, FSM states and request record for cache_ctrl
package cache_ctrl_pkg;
    localparam int CACHE_DEPTH = 1024;
    localparam int CIDX_W      = $clog2(CACHE_DEPTH);
    localparam int CTAG_W      = 32 - CIDX_W - 2;

    typedef enum logic [1:0] {
        LOOKUP,
        WBACK,
        REFILL,
        FILL
    } cache_state_e;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cache_req_t;
endpackage

// File: rtl/cache_stat.sv
// rtl/cache_stat.sv - saturating hit/miss/write-back event counters
module cache_stat (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hit,
    input  logic        i_miss,
    input  logic        i_wb,
    output logic [31:0] o_hit,
    output logic [31:0] o_miss,
    output logic [31:0] o_wb
);
    logic [31:0] r_hit, r_miss, r_wb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit  <= '0;
            r_miss <= '0;
            r_wb   <= '0;
        end else begin
            if (i_hit && !(&r_hit))
                r_hit <= r_hit + 32'd1;
            if (i_miss && !(&r_miss))
                r_miss <= r_miss + 32'd1;
            if (i_wb && !(&r_wb))
                r_wb <= r_wb + 32'd1;
        end
    end

    assign o_hit  = r_hit;
    assign o_miss = r_miss;
    assign o_wb   = r_wb;
endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - miss handler for a direct-mapped cache group; CACHE_STAT_EN adds event counters
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT_W = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [1:0]        cpu_size,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic [31:0]       grp_addr,
    output logic [1:0]        grp_size,
    input  logic              grp_hit,
    output logic              grp_rep,
    output logic              grp_we,
    output logic              grp_wp,
    output logic              grp_wm,
    output logic              grp_wd,
    output logic [31:0]       grp_data_w,
    input  logic              grp_need_r,
    input  logic [CTAG_W-1:0] grp_ctag_r,
    input  logic [31:0]       grp_data_r,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic [31:0]       stat_hit,
    output logic [31:0]       stat_miss,
    output logic [31:0]       stat_wb
);
    cache_state_e r_state;
    cache_req_t   r_req;
    logic         r_replay;
    logic [31:0]  r_vic_addr, r_vic_data, r_fill_data;

    logic         w_req, w_wr, w_lookup, w_fill, w_hit, w_miss, w_wd_expire;
    logic [1:0]   w_size;
    logic [31:0]  w_addr, w_wdata;

    // A pending replay takes priority over the live CPU inputs.
    assign w_req    = (r_replay | cpu_req) & ~rst;
    assign w_wr     = r_replay ? r_req.wr    : cpu_wr;
    assign w_size   = r_replay ? r_req.size  : cpu_size;
    assign w_addr   = r_replay ? r_req.addr  : cpu_addr;
    assign w_wdata  = r_replay ? r_req.wdata : cpu_wdata;
    assign w_lookup = (r_state == LOOKUP);
    assign w_fill   = (r_state == FILL);
    assign w_hit    = w_lookup & w_req & grp_hit;
    assign w_miss   = w_lookup & w_req & ~grp_hit;

    assign cpu_rdata  = grp_data_r;
    assign cpu_stall  = rst | ~w_lookup | w_miss;
    assign grp_addr   = w_lookup ? w_addr : r_req.addr;
    assign grp_size   = w_lookup ? w_size : r_req.size;
    assign grp_we     = (w_hit & w_wr) | w_fill;
    assign grp_wp     = w_fill;
    assign grp_rep    = w_fill;
    assign grp_wm     = w_fill;
    assign grp_wd     = w_hit & w_wr;
    assign grp_data_w = w_fill ? r_fill_data : w_wdata;

    assign mem_req   = (r_state == WBACK) | (r_state == REFILL);
    assign mem_wr    = (r_state == WBACK);
    assign mem_addr  = mem_wr ? r_vic_addr : {r_req.addr[31:2], 2'b00};
    assign mem_wdata = r_vic_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LOOKUP;
            r_req       <= '0;
            r_replay    <= 1'b0;
            r_vic_addr  <= '0;
            r_vic_data  <= '0;
            r_fill_data <= '0;
        end else if (w_wd_expire) begin
            r_state  <= LOOKUP;
            r_replay <= 1'b0;
        end else begin
            case (r_state)
                LOOKUP: begin
                    if (w_miss) begin
                        r_req      <= {w_wr, w_size, w_addr, w_wdata};
                        r_vic_addr <= {grp_ctag_r, w_addr[CIDX_W+1:2], 2'b00};
                        r_vic_data <= grp_data_r;
                        r_replay   <= 1'b0;
                        r_state    <= grp_need_r ? WBACK : REFILL;
                    end else if (w_hit) begin
                        r_replay <= 1'b0;
                    end
                end
                WBACK: begin
                    if (mem_ack)
                        r_state <= REFILL;
                end
                REFILL: begin
                    if (mem_ack) begin
                        r_fill_data <= mem_rdata;
                        r_state     <= FILL;
                    end
                end
                FILL: begin
                    r_replay <= 1'b1;
                    r_state  <= LOOKUP;
                end
                default: r_state <= LOOKUP;
            endcase
        end
    end

    generate
        if (MEM_TIMEOUT_W > 0) begin : g_wd
            logic [MEM_TIMEOUT_W-1:0] r_wd_cnt;
            assign w_wd_expire = mem_req & ~mem_ack & (&r_wd_cnt);
            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    r_wd_cnt <= '0;
                else if (!mem_req || mem_ack || w_wd_expire)
                    r_wd_cnt <= '0;
                else
                    r_wd_cnt <= r_wd_cnt + 1'b1;
            end
        end else begin : g_no_wd
            assign w_wd_expire = 1'b0;
        end
    endgenerate

`ifdef CACHE_STAT_EN
    cache_stat u_stat (
        .clk    (clk),
        .rst    (rst),
        .i_hit  (w_hit & ~r_replay),
        .i_miss (w_miss),
        .i_wb   (mem_wr & mem_ack),
        .o_hit  (stat_hit),
        .o_miss (stat_miss),
        .o_wb   (stat_wb)
    );
`else
    assign stat_hit  = '0;
    assign stat_miss = '0;
    assign stat_wb   = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - self-checking bench for cache_ctrl with group and memory models
module tb_cache_ctrl;
    import cache_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0, cpu_wr = 1'b0;
    logic [1:0]        cpu_size = 2'b10;
    logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
    logic [31:0]       cpu_rdata;
    logic              cpu_stall;
    logic [31:0]       grp_addr;
    logic [1:0]        grp_size;
    logic              grp_hit, grp_rep, grp_we, grp_wp, grp_wm, grp_wd;
    logic [31:0]       grp_data_w;
    logic              grp_need_r;
    logic [CTAG_W-1:0] grp_ctag_r;
    logic [31:0]       grp_data_r;
    logic              mem_req, mem_wr;
    logic [31:0]       mem_addr, mem_wdata;
    logic [31:0]       mem_rdata = '0;
    logic              mem_ack;
    logic [31:0]       stat_hit, stat_miss, stat_wb;

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_size(cpu_size), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .grp_addr(grp_addr), .grp_size(grp_size), .grp_hit(grp_hit), .grp_rep(grp_rep),
        .grp_we(grp_we), .grp_wp(grp_wp), .grp_wm(grp_wm), .grp_wd(grp_wd),
        .grp_data_w(grp_data_w), .grp_need_r(grp_need_r), .grp_ctag_r(grp_ctag_r),
        .grp_data_r(grp_data_r),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stat_hit(stat_hit), .stat_miss(stat_miss), .stat_wb(stat_wb)
    );

    // Cache group model: one word per line, byte/half merge on store hits.
    logic [31:0]       g_data [CACHE_DEPTH];
    logic [CTAG_W-1:0] g_tag  [CACHE_DEPTH];
    logic              g_v    [CACHE_DEPTH];
    logic              g_d    [CACHE_DEPTH];
    logic [CIDX_W-1:0] g_idx;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] r;
        r = old;
        if (sz == 2'b00)      r[8*off +: 8]      = wd[7:0];
        else if (sz == 2'b01) r[16*off[1] +: 16] = wd[15:0];
        else                  r = wd;
        return r;
    endfunction

    always_comb begin
        g_idx      = grp_addr[CIDX_W+1:2];
        grp_hit    = g_v[g_idx] && (g_tag[g_idx] == grp_addr[31:CIDX_W+2]);
        grp_need_r = g_v[g_idx] && g_d[g_idx];
        grp_ctag_r = g_tag[g_idx];
        grp_data_r = g_v[g_idx] ? g_data[g_idx] : 32'h0;
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CACHE_DEPTH; i++) g_v[i] <= 1'b0;
        end else if (grp_we) begin
            if (grp_wp) begin
                g_tag[g_idx]  <= grp_addr[31:CIDX_W+2];
                g_v[g_idx]    <= 1'b1;
                g_d[g_idx]    <= grp_wd;
                g_data[g_idx] <= grp_data_w;
            end else begin
                g_d[g_idx]    <= g_d[g_idx] | grp_wd;
                g_data[g_idx] <= merge(g_data[g_idx], grp_data_w, grp_size, grp_addr[1:0]);
            end
        end
    end

    // Memory model: ack arrives ack_delay cycles after the request is first seen.
    logic [31:0] mem_store [16384];
    int          ack_delay = 0;
    int          mcnt;
    logic        r_ack, stray_ack = 1'b0;
    assign mem_ack = r_ack | stray_ack;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack <= 1'b0;
            mcnt  <= 0;
        end else begin
            r_ack <= 1'b0;
            if (mem_req && !r_ack) begin
                if (mcnt >= ack_delay) begin
                    r_ack <= 1'b1;
                    mcnt  <= 0;
                    if (mem_wr) mem_store[mem_addr[15:2]] <= mem_wdata;
                    else        mem_rdata <= mem_store[mem_addr[15:2]];
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    typedef struct packed {logic [31:0] addr; logic [31:0] data;} wb_t;
    wb_t wb_q[$];
    always @(posedge clk)
        if (!rst && mem_req && mem_wr && r_ack) wb_q.push_back({mem_addr, mem_wdata});

    logic        stable_en = 1'b0;
    logic [31:0] stable_addr = '0;
    int          req_cycles = 0, stable_bad = 0;
    always @(negedge clk)
        if (stable_en && mem_req) begin
            req_cycles <= req_cycles + 1;
            if (mem_addr !== stable_addr || mem_wr !== 1'b0) stable_bad <= stable_bad + 1;
        end

    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        int          exp_stall;
        string       name;
    } vec_t;

    vec_t exp_q[$];
    vec_t vecs[6];

    task automatic do_access(input vec_t v);
        int   stalls;
        bit   done;
        logic [31:0] rd;
        vec_t e;
        exp_q.push_back(v);
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = v.wr; cpu_size = v.size; cpu_addr = v.addr; cpu_wdata = v.wdata;
        stalls = 0; done = 0; rd = '0;
        for (int c = 0; c < 200 && !done; c++) begin
            #2;
            if (!cpu_stall) begin
                done = 1;
                rd   = cpu_rdata;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        @(negedge clk);
        cpu_req = 1'b0;
        e = exp_q.pop_front();
        if (!done) chk({e.name, "_timeout"}, 32'd0, 32'd1);
        chk({e.name, "_stall"}, stalls, e.exp_stall);
        if (e.chk_rd) chk({e.name, "_rdata"}, rd, e.exp_rdata);
    endtask

    task automatic chk_stats(input string tag, input int h, input int m, input int w);
`ifdef CACHE_STAT_EN
        chk({tag, "_stat_hit"},  stat_hit,  h);
        chk({tag, "_stat_miss"}, stat_miss, m);
        chk({tag, "_stat_wb"},   stat_wb,   w);
`else
        chk({tag, "_stat_hit"},  stat_hit,  0);
        chk({tag, "_stat_miss"}, stat_miss, 0);
        chk({tag, "_stat_wb"},   stat_wb,   0);
        if (h + m + w < 0) chk({tag, "_stat_args"}, 0, 1);
`endif
    endtask

    initial begin
        vec_t v;
        bit   seen;
        for (int i = 0; i < 16384; i++) mem_store[i] = 32'h0;
        for (int i = 0; i < CACHE_DEPTH; i++) begin
            g_d[i] = 1'b0; g_tag[i] = '0; g_data[i] = '0;
        end
        mem_store[32'h1000 >> 2] = 32'hDEADBEEF;
        mem_store[32'h5000 >> 2] = 32'h12345678;
        mem_store[32'h2004 >> 2] = 32'h0BADF00D;

        vecs[0] = '{1'b0, 2'b10, 32'h1000, 32'h0,        1'b1, 32'hDEADBEEF, 4, "load_miss"};
        vecs[1] = '{1'b0, 2'b10, 32'h1000, 32'h0,        1'b1, 32'hDEADBEEF, 0, "reload_hit"};
        vecs[2] = '{1'b1, 2'b00, 32'h1001, 32'hAB,       1'b0, 32'h0,        0, "byte_store"};
        vecs[3] = '{1'b0, 2'b10, 32'h1000, 32'h0,        1'b1, 32'hDEADABEF, 0, "load_merged"};
        vecs[4] = '{1'b1, 2'b10, 32'h5000, 32'hCAFEF00D, 1'b0, 32'h0,        6, "dirty_store"};
        vecs[5] = '{1'b0, 2'b10, 32'h5000, 32'h0,        1'b1, 32'hCAFEF00D, 0, "load_5000"};

        #2;
        chk("rst_stall",   cpu_stall, 1);
        chk("rst_mem_req", mem_req,   0);
        chk("rst_grp_we",  grp_we,    0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("idle_stall",   cpu_stall, 0);
        chk("idle_mem_req", mem_req,   0);
        chk_stats("reset", 0, 0, 0);

        @(negedge clk);
        stray_ack = 1'b1;
        @(negedge clk);
        stray_ack = 1'b0;
        #2;
        chk("stray_ack_stall",   cpu_stall, 0);
        chk("stray_ack_mem_req", mem_req,   0);

        for (int i = 0; i < 5; i++) do_access(vecs[i]);
        chk("wb_count", wb_q.size(), 1);
        if (wb_q.size() > 0) begin
            chk("wb_addr", wb_q[0].addr, 32'h1000);
            chk("wb_data", wb_q[0].data, 32'hDEADABEF);
        end
        chk("line_dirty", g_d[0], 1);
        chk("line_data",  g_data[0], 32'hCAFEF00D);
        chk_stats("mix", 3, 2, 1);
        do_access(vecs[5]);

        ack_delay = 7;
        stable_addr = 32'h2004;
        stable_en = 1'b1;
        v = '{1'b0, 2'b10, 32'h2004, 32'h0, 1'b1, 32'h0BADF00D, 11, "slow_refill"};
        do_access(v);
        stable_en = 1'b0;
        chk("slow_req_cycles", req_cycles, 9);
        chk("slow_addr_stable", stable_bad, 0);

        v = '{1'b1, 2'b10, 32'h2004, 32'h11112222, 1'b0, 32'h0, 0, "dirty_2004"};
        do_access(v);
        ack_delay = 5;
        @(negedge clk);
        cpu_req = 1'b1; cpu_wr = 1'b0; cpu_size = 2'b10; cpu_addr = 32'h6004;
        seen = 0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            #1;
            if (mem_req && mem_wr) seen = 1;
        end
        if (!seen) chk("wback_entry_timeout", 0, 1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", mem_req,   0);
        chk("midrst_stall",   cpu_stall, 1);
        cpu_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ack_delay = 0;
        #2;
        chk("postrst_mem_req", mem_req,   0);
        chk("postrst_stall",   cpu_stall, 0);
        chk("aborted_wb", mem_store[32'h2004 >> 2], 32'h0BADF00D);
        v = '{1'b0, 2'b10, 32'h1000, 32'h0, 1'b1, 32'hDEADABEF, 4, "post_rst_load"};
        do_access(v);
        chk_stats("postrst", 0, 1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
